// File: rtl/demux_pkg.sv
// Shared definitions for the 1-to-2 packet demultiplexer.
//   state_t    : packet-routing FSM state (IDLE between packets, BUSY mid-packet)
//   ROUTE_OUT0 : route code selecting branch 0
//   ROUTE_OUT1 : route code selecting branch 1
package demux_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  localparam logic ROUTE_OUT0 = 1'b0;
  localparam logic ROUTE_OUT1 = 1'b1;

endpackage

// File: rtl/stream_slot.sv
// One-entry valid/ready output register.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   load            : write load_data/load_last into the slot this cycle
//   load_data/last  : beat to store
//   ready           : downstream accepts the held beat
//   valid/data/last : registered beat presented downstream
//   free            : slot can take a beat this cycle (empty, or draining now)
module stream_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          last,
  output logic          free
);

  logic          vld_p1;
  logic [DW-1:0] data_p1;
  logic          last_p1;

  assign free  = !vld_p1 || ready;
  assign valid = vld_p1;
  assign data  = data_p1;
  assign last  = last_p1;

  // Output register stage: a load wins over a drain, so a simultaneous
  // drain+load keeps the slot full with the new beat. Without a load the
  // held beat stays put until the downstream takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      last_p1 <= 1'b0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= load_data;
      last_p1 <= load_last;
    end else if (ready) begin
      vld_p1  <= 1'b0;
    end
  end

endmodule

// File: rtl/demux1to2_stream.sv
// Registered 1-to-2 packet demultiplexer.
// The route is taken from in_sel on the first beat of a packet and held
// until the in_last beat is accepted. Each branch has a one-entry output
// register (1-cycle latency, full throughput).
// Ports:
//   clk, rst_n                 : clock, synchronous active-low reset
//   in_data/valid/last/sel     : input stream and packet route (0 -> out0)
//   in_ready                   : input beat accepted when high with in_valid
//   out0_* / out1_*            : branch streams (data, valid, last, ready)
//   busy                       : a packet is mid-flight
//   pkt_cnt0 / pkt_cnt1        : completed-packet counters (wrapping), only
//                                present when DEMUX_CNT_EN is defined
module demux1to2_stream
  import demux_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_last,
  input  logic          in_sel,
  output logic          in_ready,
  output logic [DW-1:0] out0_data,
  output logic          out0_valid,
  output logic          out0_last,
  input  logic          out0_ready,
  output logic [DW-1:0] out1_data,
  output logic          out1_valid,
  output logic          out1_last,
  input  logic          out1_ready,
  output logic          busy
`ifdef DEMUX_CNT_EN
  ,
  output logic [CW-1:0] pkt_cnt0,
  output logic [CW-1:0] pkt_cnt1
`endif
);

  if (DW < 1 || CW < 1) begin : g_param_chk
    $error("demux1to2_stream: DW and CW must be at least 1");
  end

  state_t state_q;
  logic   sel_q;
  logic   route;
  logic   accept;
  logic   free0;
  logic   free1;
  logic   load0;
  logic   load1;

  // Mid-packet the latched route wins, so in_sel toggling on later beats
  // cannot split a packet across branches.
  assign route    = (state_q == ST_BUSY) ? sel_q : in_sel;
  assign in_ready = (route == ROUTE_OUT1) ? free1 : free0;
  assign accept   = in_valid && in_ready;
  assign load0    = accept && (route == ROUTE_OUT0);
  assign load1    = accept && (route == ROUTE_OUT1);
  assign busy     = (state_q == ST_BUSY);

  // Packet FSM: a single-beat packet never leaves IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sel_q   <= ROUTE_OUT0;
    end else if (accept) begin
      if (state_q == ST_IDLE && !in_last) begin
        state_q <= ST_BUSY;
        sel_q   <= in_sel;
      end else if (state_q == ST_BUSY && in_last) begin
        state_q <= ST_IDLE;
      end
    end
  end

  stream_slot #(.DW(DW)) u_slot0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load0),
    .load_data (in_data),
    .load_last (in_last),
    .ready     (out0_ready),
    .valid     (out0_valid),
    .data      (out0_data),
    .last      (out0_last),
    .free      (free0)
  );

  stream_slot #(.DW(DW)) u_slot1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load1),
    .load_data (in_data),
    .load_last (in_last),
    .ready     (out1_ready),
    .valid     (out1_valid),
    .data      (out1_data),
    .last      (out1_last),
    .free      (free1)
  );

`ifdef DEMUX_CNT_EN
  // Completed-packet counters: count last beats as they leave each branch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      if (out0_valid && out0_ready && out0_last) pkt_cnt0 <= pkt_cnt0 + CW'(1);
      if (out1_valid && out1_ready && out1_last) pkt_cnt1 <= pkt_cnt1 + CW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_demux1to2_stream.sv
module tb_demux1to2_stream;

  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_sel = 1'b0;
  logic          in_ready;
  logic [DW-1:0] out0_data, out1_data;
  logic          out0_valid, out1_valid;
  logic          out0_last, out1_last;
  logic          out0_ready = 1'b1;
  logic          out1_ready = 1'b1;
  logic          busy;
`ifdef DEMUX_CNT_EN
  logic [CW-1:0] pkt_cnt0, pkt_cnt1;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  demux1to2_stream #(.DW(DW), .CW(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_sel     (in_sel),
    .in_ready   (in_ready),
    .out0_data  (out0_data),
    .out0_valid (out0_valid),
    .out0_last  (out0_last),
    .out0_ready (out0_ready),
    .out1_data  (out1_data),
    .out1_valid (out1_valid),
    .out1_last  (out1_last),
    .out1_ready (out1_ready),
    .busy       (busy)
`ifdef DEMUX_CNT_EN
    ,
    .pkt_cnt0   (pkt_cnt0),
    .pkt_cnt1   (pkt_cnt1)
`endif
  );

  // Reference model: each branch is a queue of pending {last,data} beats
  // holding at most one entry; packets are tracked as "inside a packet, on route r".
  logic [DW:0]   q0[$];
  logic [DW:0]   q1[$];
  bit            m_known = 1'b0;
  logic          m_busy = 1'b0;
  logic          m_route = 1'b0;
  logic [CW-1:0] m_cnt0 = '0;
  logic [CW-1:0] m_cnt1 = '0;

  function automatic logic model_ready();
    logic r;
    r = m_busy ? m_route : in_sel;
    if (r) return (q1.size() == 0) || out1_ready;
    return (q0.size() == 0) || out0_ready;
  endfunction

  always @(posedge clk) begin : model
    logic take;
    if (!rst_n) begin
      q0.delete();
      q1.delete();
      m_busy  <= 1'b0;
      m_known <= 1'b1;
      m_cnt0  <= '0;
      m_cnt1  <= '0;
    end else if (m_known) begin
      take = in_valid && model_ready();
      if (out0_ready && q0.size() != 0) begin
        if (q0[0][DW]) m_cnt0 <= m_cnt0 + 1'b1;
        void'(q0.pop_front());
      end
      if (out1_ready && q1.size() != 0) begin
        if (q1[0][DW]) m_cnt1 <= m_cnt1 + 1'b1;
        void'(q1.pop_front());
      end
      if (take) begin
        if ((m_busy ? m_route : in_sel) == 1'b1) q1.push_back({in_last, in_data});
        else q0.push_back({in_last, in_data});
        if (!m_busy && !in_last) begin
          m_busy  <= 1'b1;
          m_route <= in_sel;
        end else if (m_busy && in_last) begin
          m_busy <= 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic s, input logic l, input logic [DW-1:0] d);
    in_valid = v;
    in_sel   = s;
    in_last  = l;
    in_data  = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 8'hFF);
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b%b want 00", out0_valid, out1_valid); end
    n_cmp++; if (out0_last !== 1'b0 || out1_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b%b want 00", out0_last, out1_last); end
    n_cmp++; if (out0_data !== 8'h00 || out1_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h %h want 00 00", out0_data, out1_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef DEMUX_CNT_EN
    n_cmp++; if (pkt_cnt0 !== '0 || pkt_cnt1 !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d %0d want 0 0", pkt_cnt0, pkt_cnt1); end
`endif
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
  endtask

  task automatic test_route_hold();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'h11);
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL hold_rdy0: got %b want 1", in_ready); end
    tick();
    drive(1'b1, 1'b0, 1'b0, 8'h22);
    @(negedge clk);
    n_cmp++; if ({out1_valid, out1_data, out1_last} !== {1'b1, 8'h11, 1'b0}) begin n_bad++; $display("FAIL hold_b0: got v%b d%h l%b want v1 d11 l0", out1_valid, out1_data, out1_last); end
    n_cmp++; if (out0_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL hold_b0_ctl: got v0=%b busy=%b want 0 1", out0_valid, busy); end
    tick();
    drive(1'b1, 1'b0, 1'b1, 8'h33);
    @(negedge clk);
    n_cmp++; if ({out1_valid, out1_data, out1_last} !== {1'b1, 8'h22, 1'b0}) begin n_bad++; $display("FAIL hold_b1: got v%b d%h l%b want v1 d22 l0", out1_valid, out1_data, out1_last); end
    n_cmp++; if (out0_valid !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL hold_b1_ctl: got v0=%b busy=%b want 0 1", out0_valid, busy); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    n_cmp++; if ({out1_valid, out1_data, out1_last} !== {1'b1, 8'h33, 1'b1}) begin n_bad++; $display("FAIL hold_b2: got v%b d%h l%b want v1 d33 l1", out1_valid, out1_data, out1_last); end
    n_cmp++; if (out0_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL hold_b2_ctl: got v0=%b busy=%b want 0 0", out0_valid, busy); end
    tick();
    @(negedge clk);
    n_cmp++; if (out1_valid !== 1'b0) begin n_bad++; $display("FAIL hold_drained: got %b want 0", out1_valid); end
    tick();
  endtask

  task automatic test_stall();
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'hA0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 8'hA1);
    @(negedge clk);
    n_cmp++; if ({out0_valid, out0_data} !== {1'b1, 8'hA0}) begin n_bad++; $display("FAIL stall_a0: got v%b d%h want v1 dA0", out0_valid, out0_data); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_rdy: got %b want 0", in_ready); end
    tick();
    @(negedge clk);
    n_cmp++; if ({out0_valid, out0_data, out0_last, in_ready} !== {1'b1, 8'hA0, 1'b0, 1'b0}) begin n_bad++; $display("FAIL stall_hold: got v%b d%h l%b r%b want v1 dA0 l0 r0", out0_valid, out0_data, out0_last, in_ready); end
    tick();
    out0_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release_rdy: got %b want 1", in_ready); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    n_cmp++; if ({out0_valid, out0_data, out0_last} !== {1'b1, 8'hA1, 1'b1}) begin n_bad++; $display("FAIL stall_a1: got v%b d%h l%b want v1 dA1 l1", out0_valid, out0_data, out0_last); end
    n_cmp++; if (out1_valid !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL stall_ctl: got v1=%b busy=%b want 0 0", out1_valid, busy); end
    tick();
    @(negedge clk);
    n_cmp++; if (out0_valid !== 1'b0) begin n_bad++; $display("FAIL stall_drained: got %b want 0", out0_valid); end
    tick();
  endtask

  task automatic test_independent();
    out0_ready = 1'b0;
    out1_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 8'h05);
    tick();
    drive(1'b1, 1'b1, 1'b1, 8'h06);
    @(negedge clk);
    n_cmp++; if ({out0_valid, out0_data} !== {1'b1, 8'h05}) begin n_bad++; $display("FAIL indep_05: got v%b d%h want v1 d05", out0_valid, out0_data); end
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL indep_rdy: got r%b busy%b want r1 busy0", in_ready, busy); end
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    n_cmp++; if ({out1_valid, out1_data, out1_last} !== {1'b1, 8'h06, 1'b1}) begin n_bad++; $display("FAIL indep_06: got v%b d%h l%b want v1 d06 l1", out1_valid, out1_data, out1_last); end
    n_cmp++; if ({out0_valid, out0_data} !== {1'b1, 8'h05}) begin n_bad++; $display("FAIL indep_05_held: got v%b d%h want v1 d05", out0_valid, out0_data); end
    tick();
    out0_ready = 1'b1;
    tick();
    @(negedge clk);
    n_cmp++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin n_bad++; $display("FAIL indep_drained: got %b%b want 00", out0_valid, out1_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 8'hB0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 8'hB1);
    tick();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (out0_valid !== 1'b0 || out1_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid: got %b%b want 00", out0_valid, out1_valid); end
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 8'hC0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    n_cmp++; if ({out0_valid, out0_data, out0_last, out1_valid} !== {1'b1, 8'hC0, 1'b1, 1'b0}) begin n_bad++; $display("FAIL midrst_new: got v0%b d%h l%b v1%b want v01 dC0 l1 v10", out0_valid, out0_data, out0_last, out1_valid); end
    tick();
    tick();
  endtask

`ifdef DEMUX_CNT_EN
  task automatic test_counter_wrap();
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b1, 8'(8'h70 + k));
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    @(negedge clk);
    n_cmp++; if (pkt_cnt1 !== 2'd1) begin n_bad++; $display("FAIL cnt_wrap1: got %0d want 1", pkt_cnt1); end
    n_cmp++; if (pkt_cnt0 !== 2'd0) begin n_bad++; $display("FAIL cnt_wrap0: got %0d want 0", pkt_cnt0); end
    tick();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_sel     = 1'($urandom_range(0, 1));
      in_last    = ($urandom_range(0, 2) == 0);
      in_data    = 8'($urandom);
      out0_ready = ($urandom_range(0, 3) != 0);
      out1_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      n_cmp++; if (in_ready !== model_ready()) begin n_bad++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, in_ready, model_ready()); end
      n_cmp++; if (busy !== m_busy) begin n_bad++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, busy, m_busy); end
      n_cmp++; if (out0_valid !== (q0.size() != 0)) begin n_bad++; $display("FAIL rnd_v0[%0d]: got %b want %b", i, out0_valid, q0.size() != 0); end
      n_cmp++; if (out1_valid !== (q1.size() != 0)) begin n_bad++; $display("FAIL rnd_v1[%0d]: got %b want %b", i, out1_valid, q1.size() != 0); end
      if (q0.size() != 0) begin
        n_cmp++; if ({out0_last, out0_data} !== q0[0]) begin n_bad++; $display("FAIL rnd_beat0[%0d]: got %h want %h", i, {out0_last, out0_data}, q0[0]); end
      end
      if (q1.size() != 0) begin
        n_cmp++; if ({out1_last, out1_data} !== q1[0]) begin n_bad++; $display("FAIL rnd_beat1[%0d]: got %h want %h", i, {out1_last, out1_data}, q1[0]); end
      end
`ifdef DEMUX_CNT_EN
      n_cmp++; if (pkt_cnt0 !== m_cnt0 || pkt_cnt1 !== m_cnt1) begin n_bad++; $display("FAIL rnd_cnt[%0d]: got %0d %0d want %0d %0d", i, pkt_cnt0, pkt_cnt1, m_cnt0, m_cnt1); end
`endif
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    test_reset();
    test_route_hold();
    test_stall();
    test_independent();
    test_reset_mid();
`ifdef DEMUX_CNT_EN
    test_counter_wrap();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
